// File: rtl/serializador.sv
// Parallel-to-serial word transmitter with per-bit flow control and a
// word-level acknowledge handshake guarded by a timeout.
module serializador #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk_100KHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  rx_ready_in,
  output logic                  data_out,
  output logic                  write_out,
  input  logic                  ack_in,
  output logic                  busy_out,
  output logic                  timeout_out,
  output logic [7:0]            sent_count_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [7:0]       TMO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [7:0]            tmo_cnt;

  logic accept;
  logic shift;
  logic last_bit;
  logic acked;
  logic expired;

  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An ack arriving in the expiry cycle wins over the timeout.
  always_comb begin
    accept     = (state == IDLE) && valid_in;
    shift      = (state == SEND) && rx_ready_in;
    last_bit   = shift && (bit_cnt == LAST_BIT);
    acked      = (state == WAIT_ACK) && ack_in;
    expired    = (state == WAIT_ACK) && !ack_in && (tmo_cnt == TMO_LAST);
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = SEND;
      SEND:     if (last_bit) next_state = WAIT_ACK;
      WAIT_ACK: if (acked || expired) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state == IDLE);
    busy_out  = !ready_out;
  end

  // Serial outputs are registered; data_out holds its last bit while stalled.
  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      tmo_cnt        <= '0;
      data_out       <= 1'b0;
      write_out      <= 1'b0;
      timeout_out    <= 1'b0;
      sent_count_out <= '0;
    end else begin
      write_out   <= 1'b0;
      timeout_out <= 1'b0;
      if (accept) begin
        shreg   <= data_in;
        bit_cnt <= '0;
      end
      if (shift) begin
        data_out  <= shreg[DATA_WIDTH-1];
        write_out <= 1'b1;
        shreg     <= shreg << 1;
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
      if (last_bit) begin
        tmo_cnt <= '0;
      end else if ((state == WAIT_ACK) && !acked && !expired) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (acked) begin
        sent_count_out <= sent_count_out + 8'd1;
      end
      if (expired) begin
        timeout_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: a scoreboard queue of expected serial
// bits and timeout cycles, drained by a monitor on the falling edge.
module tb_serializador;

  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          clk_100KHz = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic          rx_ready_in;
  logic          data_out;
  logic          write_out;
  logic          ack_in;
  logic          busy_out;
  logic          timeout_out;
  logic [7:0]    sent_count_out;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  logic [7:0]  exp_count = 8'd0;
  bit          exp_bits[$];
  int unsigned exp_tmo[$];
  bit          mon_bit;
  int unsigned mon_tmo;

  serializador #(
    .DATA_WIDTH (DW),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk_100KHz    (clk_100KHz),
    .reset         (reset),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .rx_ready_in   (rx_ready_in),
    .data_out      (data_out),
    .write_out     (write_out),
    .ack_in        (ack_in),
    .busy_out      (busy_out),
    .timeout_out   (timeout_out),
    .sent_count_out(sent_count_out)
  );

  always #5 clk_100KHz = ~clk_100KHz;

  always @(posedge clk_100KHz) cyc <= cyc + 1;

  // Monitor: every strobe and every timeout pulse must match the scoreboard.
  always @(negedge clk_100KHz) begin
    if (write_out === 1'b1) begin
      strobes++;
      checks++;
      if (exp_bits.size() == 0) begin
        errors++;
        $display("[TB] FAIL stray_strobe cycle %0d: write_out=1 required 0", cyc);
      end else begin
        mon_bit = exp_bits.pop_front();
        if (data_out !== mon_bit) begin
          errors++;
          $display("[TB] FAIL serial_bit cycle %0d: data_out=%0b required %0b", cyc, data_out, mon_bit);
        end
      end
    end
    if (timeout_out === 1'b1) begin
      checks++;
      if (exp_tmo.size() == 0) begin
        errors++;
        $display("[TB] FAIL stray_timeout cycle %0d: timeout_out=1 required 0", cyc);
      end else begin
        mon_tmo = exp_tmo.pop_front();
        if (cyc != mon_tmo) begin
          errors++;
          $display("[TB] FAIL timeout_cycle: pulse at %0d required %0d", cyc, mon_tmo);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk_100KHz);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_100KHz);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(w[DW-1-i]);
  endtask

  task automatic acceptWord(input logic [7:0] w, input int nbits);
    int guard;
    guard = 0;
    data_in  = w;
    valid_in = 1'b1;
    while (ready_out !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput("ready_before_accept", ready_out, 1);
    pushWord(w, nbits);
    tick();
    valid_in = 1'b0;
    checkOutput("busy_after_accept", busy_out, 1);
  endtask

  task automatic sendBits(input logic [7:0] w, input int n, input int stall_at,
                          input int stall_len, input bit stray_ack);
    ack_in      = stray_ack;
    rx_ready_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        rx_ready_in = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          checkOutput("stall_write_low", write_out, 0);
          checkOutput("stall_data_held", data_out, w[DW-stall_at]);
        end
        rx_ready_in = 1'b1;
      end
      tick();
      checkOutput("bit_strobe", write_out, 1);
    end
    ack_in = 1'b0;
  endtask

  task automatic endWord(input int ack_delay, input bit do_ack);
    int unsigned last_edge;
    int guard;
    last_edge = cyc;
    if (do_ack) begin
      for (int d = 0; d < ack_delay; d++) begin
        tick();
        checkOutput("wait_write_low", write_out, 0);
        checkOutput("wait_busy", busy_out, 1);
      end
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      exp_count++;
      checkOutput("ready_after_ack", ready_out, 1);
      checkOutput("sent_count", sent_count_out, exp_count);
    end else begin
      exp_tmo.push_back(last_edge + TMO);
      guard = 0;
      while (ready_out !== 1'b1 && guard < 3 * TMO) begin
        tick();
        guard++;
      end
      checkOutput("ready_after_timeout", ready_out, 1);
      checkOutput("timeout_exit_cycle", cyc, last_edge + TMO);
      checkOutput("count_after_timeout", sent_count_out, exp_count);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] w, input int stall_at, input int stall_len,
                               input int ack_delay, input bit do_ack);
    acceptWord(w, DW);
    sendBits(w, DW, stall_at, stall_len, 1'b0);
    endWord(ack_delay, do_ack);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    exp_count = 8'd0;
    checkOutput("reset_write", write_out, 0);
    checkOutput("reset_ready", ready_out, 1);
    checkOutput("reset_busy", busy_out, 0);
    checkOutput("reset_data", data_out, 0);
    checkOutput("reset_timeout", timeout_out, 0);
    checkOutput("reset_count", sent_count_out, 0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int s0;
    valid_in    = 1'b0;
    data_in     = '0;
    rx_ready_in = 1'b1;
    ack_in      = 1'b0;
    doReset();

    $display("[TB] word 0xA5, ack 3 cycles after last bit");
    applyStimulus(8'hA5, -1, 0, 3, 1'b1);

    $display("[TB] word 0xC3 with a 5-cycle stall after bit 3");
    s0 = strobes;
    applyStimulus(8'hC3, 3, 5, 2, 1'b1);
    checkOutput("c3_strobe_total", strobes - s0, 8);

    $display("[TB] word 0x0F with no ack, then a follow-up word");
    applyStimulus(8'h0F, -1, 0, 0, 1'b0);
    applyStimulus(8'h5A, -1, 0, 1, 1'b1);

    $display("[TB] ack in the expiry cycle");
    applyStimulus(8'h96, -1, 0, TMO - 1, 1'b1);

    $display("[TB] reset during bit 5 of 0xFF, then 0x3C");
    acceptWord(8'hFF, 4);
    sendBits(8'hFF, 4, -1, 0, 1'b0);
    doReset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_reset_write", write_out, 0);
    end
    applyStimulus(8'h3C, -1, 0, 2, 1'b1);

    $display("[TB] held valid, stray acks, back-to-back 0x01/0x80");
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checkOutput("stray_ack_idle_count", sent_count_out, exp_count);
    checkOutput("stray_ack_idle_ready", ready_out, 1);
    acceptWord(8'h01, DW);
    valid_in = 1'b1;
    data_in  = 8'h80;
    pushWord(8'h80, DW);
    sendBits(8'h01, DW, -1, 0, 1'b1);
    checkOutput("stray_ack_send_count", sent_count_out, exp_count);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("held_word_not_taken", ready_out, 0);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    exp_count++;
    checkOutput("first_ack_count", sent_count_out, exp_count);
    checkOutput("first_idle_ready", ready_out, 1);
    tick();
    valid_in = 1'b0;
    checkOutput("second_word_busy", busy_out, 1);
    sendBits(8'h80, DW, -1, 0, 1'b0);
    endWord(0, 1'b1);

    $display("[TB] 256 acked words wrap the counter");
    doReset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] w;
      w = i[7:0];
      applyStimulus(w, -1, 0, 0, 1'b1);
    end
    checkOutput("count_wrap_zero", sent_count_out, 0);

    repeat (3) tick();
    checkOutput("bits_drained", exp_bits.size(), 0);
    checkOutput("timeouts_drained", exp_tmo.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
